mul_nibble_sequencer: RTL
=========================

// Module: mul_nibble_sequencer
// PURPOSE
//  Multi-cycle WIDTHxWIDTH unsigned multiplier controller built around one shared
//  4x4 array multiplier core (external, combinational, 8-bit product).
//  Splits operands into 4-bit nibbles and feeds one nibble pair per cycle to the core.
//  Shift-accumulates the partial products and returns the full 2*WIDTH product over a
//  valid/ready handshake. Sits between a requesting datapath and the multiplier core.
// PARAMETERS
//  WIDTH  8  operand width in bits; must be a multiple of 4 in the range 4..16
//  (derived) NIB = WIDTH/4 nibbles per operand; STEPS = NIB*NIB core cycles per product
// PORTS
//  clk        in   1        rising-edge clock, sole clock domain
//  rst        in   1        synchronous reset, active-high
//  in_valid   in   1        request carries valid operands
//  in_ready   out  1        block can accept a request this cycle
//  in_a       in   WIDTH    multiplicand, unsigned
//  in_b       in   WIDTH    multiplier, unsigned
//  core_a     out  4        nibble of A presented to the 4x4 core
//  core_b     out  4        nibble of B presented to the 4x4 core
//  core_y     in   8        core product core_a*core_b, same-cycle combinational return
//  out_valid  out  1        out_p holds a completed product
//  out_ready  in   1        consumer accepts out_p this cycle
//  out_p      out  2*WIDTH  product in_a*in_b
//  busy       out  1        high in CALC or DONE
// BEHAVIOUR
//  Reset (rst high at a clk edge): state<=IDLE, i,j<=0, acc<=0, operand regs<=0;
//   out_valid=0, out_p=0, core_a=0, core_b=0, busy=0; in_ready=0 while rst is high.
//  FSM states IDLE, CALC, DONE; all outputs decoded from registers only.
//  IDLE: in_ready=1. Handshake = in_valid & in_ready at edge: latch in_a/in_b, acc<=0,
//   i<=0, j<=0, go CALC. in_valid without handshake: no state change.
//  CALC: in_ready=0; core_a = A[4i+3:4i], core_b = B[4j+3:4j].
//   Each edge: acc <= acc + (core_y << 4*(i+j)), zero-extended to 2*WIDTH bits.
//   i is inner index (0..NIB-1), j outer; i wraps to 0 and j increments when i=NIB-1.
//   At i=j=NIB-1 the final add is taken and state -> DONE. CALC lasts exactly STEPS cycles.
//  Outside CALC core_a=core_b=0.
//  DONE: out_valid=1, out_p=acc, stable while out_ready=0 (no limit on stall).
//   out_valid & out_ready at edge -> IDLE; out_valid drops next cycle.
//  Latency: out_valid rises STEPS cycles after the accepting edge (WIDTH=8: 4 cycles).
//  Throughput: no overlap; next request accepted earliest one cycle after output handshake
//   (STEPS+2 cycles per product with out_ready held high).
//  in_valid/in_a/in_b changes during CALC/DONE are ignored; latched operands are used.
//  Accumulator is 2*WIDTH bits; the sum can never exceed (2^WIDTH-1)^2, no overflow.
//  rst during CALC or DONE aborts the operation: no out_valid, partial acc discarded.
//  out_p keeps the last product after leaving DONE, consumers use it only with out_valid.
// TESTING
//  1. WIDTH=8: in_a=8'hFF, in_b=8'hFF accepted -> 4 cycles later out_valid=1, out_p=16'hFE01.
//  2. in_a=8'h00, in_b=8'hB7 -> out_p=16'h0000; in_a=8'h2D, in_b=8'h13 -> out_p=16'h0357.
//  3. Backpressure: out_ready low 5 cycles in DONE -> out_valid and out_p held, in_ready=0.
//  4. in_valid held high with new operands during CALC -> ignored; result uses first pair.
//  5. rst pulsed on 2nd CALC cycle -> next cycle IDLE, out_valid=0, in_ready=1 after release.
//  6. WIDTH=4: 4'hF*4'hD -> out_valid one cycle after accept, out_p=8'hC3; random sweep
//     (WIDTH=8,12,16, 1000 pairs) against golden a*b with checks on core_a/core_b nibble order.

Source files
------------

// File: rtl/mul_nibble_sequencer.sv
// mul_nibble_sequencer: WIDTHxWIDTH unsigned multiply via one shared 4x4 core, one nibble pair per cycle; ports clk/rst, in_valid/in_ready/in_a/in_b request, core_a/core_b/core_y core link, out_valid/out_ready/out_p result, busy
module mul_nibble_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic [3:0]           core_a,
  output logic [3:0]           core_b,
  input  logic [7:0]           core_y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p,
  output logic                 busy
);
  localparam int NIB = WIDTH / 4;
  localparam logic [1:0] LAST = 2'(NIB - 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]         r_state;
  logic [1:0]         r_i;
  logic [1:0]         r_j;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_p;
  logic [2*WIDTH-1:0] w_term;
  logic [2*WIDTH-1:0] w_sum;
  logic               w_last;
  assign core_a    = (r_state == CALC) ? 4'(r_a >> {r_i, 2'b00}) : 4'd0;
  assign core_b    = (r_state == CALC) ? 4'(r_b >> {r_j, 2'b00}) : 4'd0;
  assign w_term    = (2*WIDTH)'(core_y) << {3'(r_i) + 3'(r_j), 2'b00};
  assign w_sum     = r_acc + w_term;
  assign w_last    = (r_i == LAST) && (r_j == LAST);
  assign in_ready  = (r_state == IDLE) && !rst;
  assign out_valid = (r_state == DONE);
  assign out_p     = r_p;
  assign busy      = (r_state == CALC) || (r_state == DONE);
  // r_p is loaded only on the final step so the result survives the next accept clearing r_acc
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_i     <= '0;
      r_j     <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_p     <= '0;
    end else if (r_state == IDLE) begin
      if (in_valid) begin
        r_a     <= in_a;
        r_b     <= in_b;
        r_acc   <= '0;
        r_i     <= '0;
        r_j     <= '0;
        r_state <= CALC;
      end
    end else if (r_state == CALC) begin
      r_acc <= w_sum;
      if (w_last) begin
        r_p     <= w_sum;
        r_state <= DONE;
      end else if (r_i == LAST) begin
        r_i <= '0;
        r_j <= r_j + 2'd1;
      end else begin
        r_i <= r_i + 2'd1;
      end
    end else if (r_state == DONE) begin
      if (out_ready) r_state <= IDLE;
    end else begin
      r_state <= IDLE;
    end
  end
endmodule
